// File: rtl/regfile_nr1w.sv
// regfile_nr1w: byte-masked 1W / NREAD-R register file.
// It clears itself in hardware after reset or CLR, has an optional
// hard-zero entry 0 and optional write-to-read forwarding.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   CLR            request a new clear sweep
//   BUSY           clear sweep in progress (accesses ignored)
//   WE, WA, WD     byte write enables, write address, write data
//   RE, RA         per-port read enables and packed read addresses
//   RD, RVALID     packed registered read data and per-port valid
module regfile_nr1w #(
    parameter int WSIZE     = 4,
    parameter int AW        = 5,
    parameter int NREAD     = 2,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CLR,
    output logic                      BUSY,
    input  logic [WSIZE-1:0]          WE,
    input  logic [AW-1:0]             WA,
    input  logic [WSIZE*8-1:0]        WD,
    input  logic [NREAD-1:0]          RE,
    input  logic [NREAD*AW-1:0]       RA,
    output logic [NREAD*WSIZE*8-1:0]  RD,
    output logic [NREAD-1:0]          RVALID
);

    localparam int W = WSIZE * 8;
    localparam int D = 1 << AW;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [AW:0]          cnt_inc;
    logic [W-1:0]         mem_q [D];
    logic [W-1:0]         mem_d [D];
    logic [NREAD*W-1:0]   rd_q, rd_d;
    logic [NREAD-1:0]     rvalid_q, rvalid_d;
    logic                 access;
    logic                 wr_en;
    logic [AW-1:0]        rd_addr;
    logic [W-1:0]         rd_word;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 1'b1;
        mem_d    = mem_q;
        rd_d     = rd_q;
        rvalid_d = '0;
        access   = 1'b0;
        wr_en    = 1'b0;
        rd_addr  = '0;
        rd_word  = '0;

        unique case (state_q)
            SWEEP: begin
                if (!RST) begin
                    mem_d[cnt_q[AW-1:0]] = '0;
                end
                cnt_d = cnt_inc;
                // Carry into the extra bit marks the last entry written.
                if (cnt_inc[AW]) begin
                    state_d = READY;
                end
                if (CLR) begin
                    cnt_d   = '0;
                    state_d = SWEEP;
                end
            end
            READY: begin
                // The CLR cycle accepts no access: its results would
                // be wiped, and RVALID must stay low once BUSY rises.
                if (CLR) begin
                    cnt_d   = '0;
                    state_d = SWEEP;
                end else begin
                    access = !RST;
                end
            end
        endcase

        wr_en = access && (WE != '0)
              && !((ZERO_REG0 != 0) && (WA == '0));

        for (int b = 0; b < WSIZE; b++) begin
            if (wr_en && WE[b]) begin
                mem_d[WA][b*8 +: 8] = WD[b*8 +: 8];
            end
        end

        for (int i = 0; i < NREAD; i++) begin
            rd_addr = RA[i*AW +: AW];
            rd_word = mem_q[rd_addr];
            if ((BYPASS != 0) && wr_en && (WA == rd_addr)) begin
                for (int b = 0; b < WSIZE; b++) begin
                    if (WE[b]) begin
                        rd_word[b*8 +: 8] = WD[b*8 +: 8];
                    end
                end
            end
            if ((ZERO_REG0 != 0) && (rd_addr == '0)) begin
                rd_word = '0;
            end
            if (access && RE[i]) begin
                rd_d[i*W +: W] = rd_word;
                rvalid_d[i]    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= SWEEP;
            cnt_q    <= '0;
            rd_q     <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Array has no reset; the sweep initialises it.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign BUSY   = (state_q == SWEEP);
    assign RD     = rd_q;
    assign RVALID = rvalid_q;

endmodule

// File: doc/regfile_nr1w.md
# regfile_nr1w

Parametrised register file with one byte-masked write port and NREAD independent registered read ports. It is the next generation of the 32×32 1RW1R register-file RAM used by the CPU core. It adds:
- configurable depth, word width and read-port count;
- a hard-wired zero entry;
- write-to-read forwarding;
- a hardware clear sweep after reset or on request, so no simulation-only initialisation is needed.

## Interface
Parameters:
- WSIZE, 4, bytes per word; word width W = WSIZE*8
- AW, 5, address width; depth D = 2^AW
- NREAD, 2, number of read ports (≥1)
- ZERO_REG0, 1, 1 = entry 0 always reads zero and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports (clock and reset first):
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- CLR  in  1  single-cycle request to re-run the clear sweep
- BUSY  out  1  high while clear sweep runs; WE/RE ignored
- WE  in  WSIZE  per-byte write enable
- WA  in  AW  write address
- WD  in  W  write data
- RE  in  NREAD  per-port read enable
- RA  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
- RD  out  NREAD*W  read data; port i at [i*W +: W]
- RVALID  out  NREAD  port i RD updated this cycle

## Operation
State machine has two states: SWEEP and READY, plus counter CNT[AW:0].
- RST high: state=SWEEP, CNT=0, BUSY=1, RD=0, RVALID=0. No array writes while RST is high.
- SWEEP, RST low: each cycle write 0 to entry CNT[AW-1:0], then CNT+1. After entry D-1 is written, go to READY; BUSY=0 from the next cycle.
- CLR high in READY: go to SWEEP with CNT=0; BUSY=1 from the next cycle.
- CLR in SWEEP: restart with CNT=0.
- RST overrides CLR.
- While BUSY=1: WE and RE are ignored and RVALID=0. RD is held, except that RST zeroes it.

Writes (READY only):
- At the rising edge, byte b of entry WA takes WD[b*8 +: 8] when WE[b]=1. Other bytes are unchanged.
- WE=0 is a no-op.
- ZERO_REG0=1 and WA=0: write dropped.

Reads (READY only):
- RE[i]=1 at edge t: RD port i is loaded with entry RA[i] and RVALID[i]=1 after edge t.
- RE[i]=0: RD port i holds its value and RVALID[i]=0.
- Ports are fully independent. Any number of ports may read the same address.
- ZERO_REG0=1 and RA[i]=0: RD port i = 0 regardless of contents or bypass.

Forwarding:
- BYPASS=1 and a same-cycle write to RA[i] (WE≠0): RD gets WD bytes where WE[b]=1 and old entry bytes elsewhere. This is the new merged value.
- BYPASS=0: RD gets the pre-write value (read-before-write).
- A write to entry 0 with ZERO_REG0=1 is never forwarded.

Widths:
- D = 2^AW, so every address is valid and no range checks are needed.
- CNT is AW+1 bits to detect end of sweep.

## Timing
- Read latency is 1 cycle: address and RE at edge t, data and RVALID valid after edge t until the next edge.
- Write latency: data is visible to a non-forwarded read issued at edge t+1 and later.
- Sweep: RST low at edges 1..D clears entries 0..D-1. BUSY=0 after edge D, and the first accepted access is at edge D+1.
- CLR sampled at edge t gives BUSY=1 after t. Sweep writes happen at edges t+1..t+D and BUSY=0 after t+D.
- RST mid-sweep: CNT returns to 0 and a full D-cycle sweep runs after RST deasserts. Partial progress is discarded.
- Reset values: BUSY=1, RD=0, RVALID=0.

## Test plan
- Reset sweep: default params, with array pre-filled via writes before RST. Pulse RST 1 cycle. Required: BUSY=1 for exactly 32 edges after deassert; then reading all 32 addresses returns 0.
- Byte mask: write 0xAABBCCDD to addr 5 with WE=1111, then write 0x11223344 with WE=0101. Read addr 5 on port 0 → 0xAA22CC44, RVALID[0]=1 one cycle after RE.
- Forwarding: entry 7=0x01020304; same cycle WE=0011, WD=0x0000BEEF, RA0=7, RE0=1. BYPASS=1 → RD0=0x0102BEEF; BYPASS=0 → RD0=0x01020304.
- Zero reg: write 0xFFFFFFFF to addr 0 with WE=1111 while both ports read addr 0 that cycle and the next. RD0=RD1=0 both cycles (ZERO_REG0=1).
- Multi-port, NREAD=3, AW=3: entries 1,2,3 = 0x11,0x22,0x33. Read RA=(3,1,1) → RD=(0x33,0x11,0x11). Then RE=010 → RVALID=010, ports 0/2 hold their old data.
- Mid-sweep reset and CLR: assert RST at sweep cycle 10 → BUSY stays high for a full 32 cycles after deassert. Issue CLR with RE=1 → no RVALID during BUSY, and the written entry reads 0 afterwards.
